memory_stage: RTL and testbench

Memory-access stage of the five-stage pipeline, directly downstream of the execute stage. It consumes the EX/MEM pipeline outputs and resolves branch redirection. It drives a single-port data-memory bus with a ready handshake, stalling the pipeline while memory is busy. It performs load/store byte-lane alignment and sign/zero extension, and registers results into the MEM/WB pipeline register.

---
 rtl/memory_stage_if.sv | 20 ++
 rtl/memory_stage.sv | 137 +++++++++++++
 tb/tb_memory_stage.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/memory_stage_if.sv
// Single-port data-memory bus between the memory stage (master) and data memory (slave).
interface memory_stage_if;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;
    logic        dmem_ready;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
        input  dmem_rdata, dmem_ready
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
        output dmem_rdata, dmem_ready
    );
endinterface

// File: rtl/memory_stage.sv
// Memory-access pipeline stage: branch resolve, data-memory handshake, lane alignment, MEM/WB register.
// Optional feature: define MISALIGN_TRAP_EN to trap misaligned half/word accesses instead of aligning them.
module memory_stage (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [2:0]           strCtrlM,
    input  logic                 RegWriteM,
    input  logic                 MemWriteM,
    input  logic                 MemtoRegM,
    input  logic                 PCBranchM,
    input  logic                 branchM,
    input  logic [31:0]          ALUoutM,
    input  logic [31:0]          PCplusImmM,
    input  logic [31:0]          r2M,
    input  logic [4:0]           rdM,
    output logic                 PCSrcM,
    output logic [31:0]          PCTargetM,
    output logic                 stallM,
    memory_stage_if.master       dmem,
    output logic                 RegWriteW,
    output logic                 MemtoRegW,
    output logic [31:0]          ALUoutW,
    output logic [31:0]          ReadDataW,
    output logic [4:0]           rdW,
    output logic                 misalignM
);

    typedef enum logic {S_IDLE, S_WAIT} stateT;

    stateT       state;
    logic        memOp;
    logic        isByte;
    logic        isHalf;
    logic        isUnsigned;
    logic        misaligned;
    logic [1:0]  off;
    logic [31:0] shifted;
    logic [31:0] loadData;

    assign PCSrcM     = PCBranchM & branchM;
    assign PCTargetM  = PCplusImmM;
    assign memOp      = MemtoRegM | MemWriteM;
    assign isByte     = (strCtrlM[1:0] == 2'b00);
    assign isHalf     = (strCtrlM[1:0] == 2'b01);
    assign isUnsigned = strCtrlM[2];

`ifdef MISALIGN_TRAP_EN
    assign misaligned = memOp & ((isHalf & ALUoutM[0]) | (!isByte && !isHalf && (ALUoutM[1:0] != 2'b00)));
    assign off        = ALUoutM[1:0];
`else
    assign misaligned = 1'b0;
    // Without the trap, low offset bits are silently dropped to the natural alignment
    always_comb begin
        off = ALUoutM[1:0];
        if (isHalf)
            off[0] = 1'b0;
        else if (!isByte)
            off = 2'b00;
    end
`endif

    // The request is held off during reset so nothing reaches memory while the pipe is flushed
    assign dmem.dmem_req   = rst & memOp & !misaligned;
    assign dmem.dmem_we    = dmem.dmem_req & MemWriteM;
    assign dmem.dmem_addr  = {ALUoutM[31:2], 2'b00};
    assign stallM          = dmem.dmem_req & !dmem.dmem_ready;

    always_comb begin
        dmem.dmem_be    = 4'b0000;
        dmem.dmem_wdata = r2M;
        if (dmem.dmem_req) begin
            if (isByte) begin
                dmem.dmem_be    = 4'b0001 << off;
                dmem.dmem_wdata = {4{r2M[7:0]}};
            end else if (isHalf) begin
                dmem.dmem_be    = 4'b0011 << off;
                dmem.dmem_wdata = {2{r2M[15:0]}};
            end else begin
                dmem.dmem_be    = 4'b1111;
            end
        end
    end

    assign shifted = dmem.dmem_rdata >> {off, 3'b000};

    always_comb begin
        loadData = dmem.dmem_rdata;
        if (isByte)
            loadData = {{24{shifted[7] & !isUnsigned}}, shifted[7:0]};
        else if (isHalf)
            loadData = {{16{shifted[15] & !isUnsigned}}, shifted[15:0]};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE:  if (dmem.dmem_req && !dmem.dmem_ready) state <= S_WAIT;
                S_WAIT:  if (dmem.dmem_ready) state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // A stalled cycle inserts a bubble; data fields keep their last value
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            RegWriteW <= 1'b0;
            MemtoRegW <= 1'b0;
            ALUoutW   <= 32'h0;
            ReadDataW <= 32'h0;
            rdW       <= 5'd0;
        end else if (stallM) begin
            RegWriteW <= 1'b0;
            MemtoRegW <= 1'b0;
        end else begin
            RegWriteW <= RegWriteM & !misaligned;
            MemtoRegW <= MemtoRegM & !misaligned;
            ALUoutW   <= ALUoutM;
            ReadDataW <= loadData;
            rdW       <= rdM;
        end
    end

`ifdef MISALIGN_TRAP_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            misalignM <= 1'b0;
        else
            misalignM <= misaligned & !stallM;
    end
`else
    assign misalignM = 1'b0;
`endif

endmodule

// File: tb/tb_memory_stage.sv
// Directed bench for memory_stage: loads, stores, stalls, branch redirect and reset abandonment.
module tb_memory_stage;

    logic        clk;
    logic        rst;
    logic [2:0]  strCtrlM;
    logic        RegWriteM, MemWriteM, MemtoRegM;
    logic        PCBranchM, branchM;
    logic [31:0] ALUoutM, PCplusImmM, r2M;
    logic [4:0]  rdM;
    logic        PCSrcM;
    logic [31:0] PCTargetM;
    logic        stallM;
    logic        RegWriteW, MemtoRegW;
    logic [31:0] ALUoutW, ReadDataW;
    logic [4:0]  rdW;
    logic        misalignM;

    int checks   = 0;
    int failures = 0;

    memory_stage_if bus ();

    memory_stage dut (
        .clk        (clk),
        .rst        (rst),
        .strCtrlM   (strCtrlM),
        .RegWriteM  (RegWriteM),
        .MemWriteM  (MemWriteM),
        .MemtoRegM  (MemtoRegM),
        .PCBranchM  (PCBranchM),
        .branchM    (branchM),
        .ALUoutM    (ALUoutM),
        .PCplusImmM (PCplusImmM),
        .r2M        (r2M),
        .rdM        (rdM),
        .PCSrcM     (PCSrcM),
        .PCTargetM  (PCTargetM),
        .stallM     (stallM),
        .dmem       (bus),
        .RegWriteW  (RegWriteW),
        .MemtoRegW  (MemtoRegW),
        .ALUoutW    (ALUoutW),
        .ReadDataW  (ReadDataW),
        .rdW        (rdW),
        .misalignM  (misalignM)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [2:0] str, input logic rw, input logic mw, input logic m2r,
                                 input logic [31:0] alu, input logic [31:0] r2, input logic [4:0] rd);
        strCtrlM   = str;
        RegWriteM  = rw;
        MemWriteM  = mw;
        MemtoRegM  = m2r;
        ALUoutM    = alu;
        r2M        = r2;
        rdM        = rd;
        PCBranchM  = 1'b0;
        branchM    = 1'b0;
        #1;
    endtask

    task automatic nextEdge();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst             = 1'b0;
        PCplusImmM      = 32'h0;
        bus.dmem_ready  = 1'b0;
        bus.dmem_rdata  = 32'h0;
        applyStimulus(3'b010, 1'b1, 1'b0, 1'b1, 32'h100, 32'h0, 5'd1);
        #1;
        checkOutput("reset_req", bus.dmem_req, 1'b0);
        checkOutput("reset_stall", stallM, 1'b0);
        nextEdge();
        checkOutput("reset_RegWriteW", RegWriteW, 1'b0);
        checkOutput("reset_ALUoutW", ALUoutW, 32'h0);
        checkOutput("reset_rdW", rdW, 5'd0);
        checkOutput("reset_misalignM", misalignM, 1'b0);
        rst = 1'b1;

        nextEdge();
        bus.dmem_ready = 1'b1;
        bus.dmem_rdata = 32'hDEADBEEF;
        applyStimulus(3'b010, 1'b1, 1'b0, 1'b1, 32'h100, 32'h0, 5'd5);
        checkOutput("lw_req", bus.dmem_req, 1'b1);
        checkOutput("lw_be", bus.dmem_be, 4'b1111);
        checkOutput("lw_addr", bus.dmem_addr, 32'h100);
        checkOutput("lw_we", bus.dmem_we, 1'b0);
        checkOutput("lw_stall", stallM, 1'b0);
        nextEdge();
        checkOutput("lw_ReadDataW", ReadDataW, 32'hDEADBEEF);
        checkOutput("lw_RegWriteW", RegWriteW, 1'b1);
        checkOutput("lw_MemtoRegW", MemtoRegW, 1'b1);
        checkOutput("lw_rdW", rdW, 5'd5);
        checkOutput("lw_ALUoutW", ALUoutW, 32'h100);

        bus.dmem_rdata = 32'h80FF1234;
        applyStimulus(3'b000, 1'b1, 1'b0, 1'b1, 32'h103, 32'h0, 5'd6);
        checkOutput("lb_be", bus.dmem_be, 4'b1000);
        nextEdge();
        checkOutput("lb_ReadDataW", ReadDataW, 32'hFFFFFF80);

        applyStimulus(3'b100, 1'b1, 1'b0, 1'b1, 32'h103, 32'h0, 5'd6);
        nextEdge();
        checkOutput("lbu_ReadDataW", ReadDataW, 32'h00000080);

        applyStimulus(3'b001, 1'b1, 1'b0, 1'b1, 32'h102, 32'h0, 5'd6);
        nextEdge();
        checkOutput("lh_ReadDataW", ReadDataW, 32'hFFFF80FF);

        applyStimulus(3'b101, 1'b1, 1'b0, 1'b1, 32'h100, 32'h0, 5'd6);
        nextEdge();
        checkOutput("lhu_ReadDataW", ReadDataW, 32'h00001234);

        applyStimulus(3'b001, 1'b0, 1'b1, 1'b0, 32'h102, 32'h0000ABCD, 5'd0);
        checkOutput("sh_be", bus.dmem_be, 4'b1100);
        checkOutput("sh_wdata", bus.dmem_wdata, 32'hABCDABCD);
        checkOutput("sh_we", bus.dmem_we, 1'b1);
        checkOutput("sh_addr", bus.dmem_addr, 32'h100);
        nextEdge();
        checkOutput("sh_RegWriteW", RegWriteW, 1'b0);

        applyStimulus(3'b010, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
        PCBranchM  = 1'b1;
        branchM    = 1'b1;
        PCplusImmM = 32'h40;
        #1;
        checkOutput("br_PCSrcM", PCSrcM, 1'b1);
        checkOutput("br_PCTargetM", PCTargetM, 32'h40);
        checkOutput("br_req", bus.dmem_req, 1'b0);
        branchM = 1'b0;
        #1;
        checkOutput("br_not_taken", PCSrcM, 1'b0);
        nextEdge();

        applyStimulus(3'b010, 1'b1, 1'b0, 1'b0, 32'h55, 32'h0, 5'd7);
        checkOutput("alu_req", bus.dmem_req, 1'b0);
        checkOutput("alu_stall_ready_ignored", stallM, 1'b0);
        nextEdge();
        checkOutput("alu_RegWriteW", RegWriteW, 1'b1);
        checkOutput("alu_ALUoutW", ALUoutW, 32'h55);
        checkOutput("alu_rdW", rdW, 5'd7);

        bus.dmem_ready = 1'b0;
        applyStimulus(3'b010, 1'b1, 1'b0, 1'b1, 32'h200, 32'h0, 5'd9);
        for (int i = 0; i < 3; i++) begin
            checkOutput("wait_stall", stallM, 1'b1);
            checkOutput("wait_req", bus.dmem_req, 1'b1);
            checkOutput("wait_addr", bus.dmem_addr, 32'h200);
            checkOutput("wait_be", bus.dmem_be, 4'b1111);
            nextEdge();
            checkOutput("wait_bubble", RegWriteW, 1'b0);
            checkOutput("wait_ALUoutW_held", ALUoutW, 32'h55);
        end
        bus.dmem_ready = 1'b1;
        bus.dmem_rdata = 32'h12345678;
        #1;
        checkOutput("wait_release", stallM, 1'b0);
        nextEdge();
        checkOutput("wait_ReadDataW", ReadDataW, 32'h12345678);
        checkOutput("wait_RegWriteW", RegWriteW, 1'b1);
        checkOutput("wait_rdW", rdW, 5'd9);

        applyStimulus(3'b000, 1'b0, 1'b1, 1'b0, 32'h201, 32'h000000A5, 5'd0);
        checkOutput("sb_req_b2b", bus.dmem_req, 1'b1);
        checkOutput("sb_be", bus.dmem_be, 4'b0010);
        checkOutput("sb_wdata", bus.dmem_wdata, 32'hA5A5A5A5);
        nextEdge();

`ifdef MISALIGN_TRAP_EN
        applyStimulus(3'b010, 1'b1, 1'b0, 1'b1, 32'h101, 32'h0, 5'd3);
        checkOutput("mis_req", bus.dmem_req, 1'b0);
        checkOutput("mis_stall", stallM, 1'b0);
        nextEdge();
        checkOutput("mis_misalignM", misalignM, 1'b1);
        checkOutput("mis_RegWriteW", RegWriteW, 1'b0);
        applyStimulus(3'b010, 1'b1, 1'b0, 1'b0, 32'h8, 32'h0, 5'd3);
        nextEdge();
        checkOutput("mis_clear", misalignM, 1'b0);
`else
        bus.dmem_rdata = 32'hCAFEF00D;
        applyStimulus(3'b010, 1'b1, 1'b0, 1'b1, 32'h101, 32'h0, 5'd3);
        checkOutput("align_lw_be", bus.dmem_be, 4'b1111);
        checkOutput("align_lw_addr", bus.dmem_addr, 32'h100);
        nextEdge();
        checkOutput("align_lw_ReadDataW", ReadDataW, 32'hCAFEF00D);
        checkOutput("align_misalignM", misalignM, 1'b0);
        bus.dmem_rdata = 32'h80FF1234;
        applyStimulus(3'b001, 1'b1, 1'b0, 1'b1, 32'h103, 32'h0, 5'd3);
        checkOutput("align_lh_be", bus.dmem_be, 4'b1100);
        nextEdge();
        checkOutput("align_lh_ReadDataW", ReadDataW, 32'hFFFF80FF);
`endif

        bus.dmem_ready = 1'b0;
        applyStimulus(3'b010, 1'b1, 1'b0, 1'b1, 32'h300, 32'h0, 5'd12);
        nextEdge();
        checkOutput("rstwait_stall", stallM, 1'b1);
        rst = 1'b0;
        #1;
        checkOutput("rstwait_req", bus.dmem_req, 1'b0);
        checkOutput("rstwait_RegWriteW", RegWriteW, 1'b0);
        checkOutput("rstwait_MemtoRegW", MemtoRegW, 1'b0);
        checkOutput("rstwait_ALUoutW", ALUoutW, 32'h0);
        checkOutput("rstwait_ReadDataW", ReadDataW, 32'h0);
        checkOutput("rstwait_rdW", rdW, 5'd0);
        nextEdge();
        checkOutput("rstwait_no_wb", RegWriteW, 1'b0);
        rst = 1'b1;
        applyStimulus(3'b010, 1'b1, 1'b0, 1'b0, 32'h77, 32'h0, 5'd4);
        nextEdge();
        checkOutput("post_rst_ALUoutW", ALUoutW, 32'h77);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
